// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port sequencer: clear pass, then round-robin writeback arbitration
module rf_wb_arbiter #(
  parameter int NUM_REGS       = 32,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb0_valid,
  output logic              wb0_ready,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              last_grant;
  logic              both_valid;
  logic              grant0;
  logic              grant1;

  // Round-robin grant: a lone requester always wins; on a conflict the one not served last wins
  always_comb begin
    both_valid = wb0_valid & wb1_valid;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (state == S_RUN) begin
      if (both_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = wb0_valid;
        grant1 = wb1_valid;
      end
    end
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign busy      = (state == S_CLEAR);

  // Clear pass, then registered write port fed by the granted requester
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      clr_ptr      <= ADDR_W'(1);
      last_grant   <= 1'b1;
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      conflict_cnt <= '0;
    end else if (state == S_CLEAR) begin
      rf_wen   <= 1'b1;
      rf_waddr <= clr_ptr;
      rf_wdata <= '0;
      clr_ptr  <= clr_ptr + ADDR_W'(1);
      if (clr_ptr == LAST_REG) begin
        state <= S_RUN;
      end
    end else begin
      if (grant0) begin
        rf_wen     <= (wb0_addr != '0);
        rf_waddr   <= wb0_addr;
        rf_wdata   <= wb0_data;
        last_grant <= 1'b0;
      end else if (grant1) begin
        rf_wen     <= (wb1_addr != '0);
        rf_waddr   <= wb1_addr;
        rf_wdata   <= wb1_data;
        last_grant <= 1'b1;
      end else begin
        rf_wen <= 1'b0;
      end
      if (both_valid && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with a request-level reference model
module tb_rf_wb_arbiter;

  localparam int NUM_REGS = 32;

  logic        clk;
  logic        reset;
  logic        wb0_valid;
  logic        wb0_ready;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb1_valid;
  logic        wb1_ready;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;
  logic [15:0] conflict_cnt;

  rf_wb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .wb0_valid    (wb0_valid),
    .wb0_ready    (wb0_ready),
    .wb0_addr     (wb0_addr),
    .wb0_data     (wb0_data),
    .wb1_valid    (wb1_valid),
    .wb1_ready    (wb1_ready),
    .wb1_addr     (wb1_addr),
    .wb1_data     (wb1_data),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy         (busy),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 0;

  // expected register-file writes, in order
  logic [4:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  // requester-side pending writes (held until accepted)
  logic        p0v, p1v;
  logic [4:0]  p0a, p1a;
  logic [31:0] p0d, p1d;

  // reference model state
  int clear_left;
  int last_winner;   // index of requester served most recently
  int exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock cycle: drive requests, predict the outcome, queue expected writes
  task automatic step(input bit rst);
    bit e0, e1;
    @(negedge clk);
    reset     = rst;
    wb0_valid = p0v; wb0_addr = p0a; wb0_data = p0d;
    wb1_valid = p1v; wb1_addr = p1a; wb1_data = p1d;
    #1;
    if (rst) begin
      clear_left  = NUM_REGS - 1;
      last_winner = 1;
      exp_cnt     = 0;
    end else begin
      chk("busy", busy, (clear_left > 0));
      chk("conflict_cnt", conflict_cnt, exp_cnt);
      if (clear_left > 0) begin
        chk("wb0_ready_clear", wb0_ready, 0);
        chk("wb1_ready_clear", wb1_ready, 0);
        exp_addr_q.push_back(5'(NUM_REGS - clear_left));
        exp_data_q.push_back(32'h0);
        clear_left--;
      end else begin
        if (p0v && p1v) begin
          e0 = (last_winner == 1);
          e1 = !e0;
          if (exp_cnt < 65535) exp_cnt++;
        end else begin
          e0 = p0v;
          e1 = p1v;
        end
        chk("wb0_ready", wb0_ready, e0);
        chk("wb1_ready", wb1_ready, e1);
        if (e0) begin
          if (p0a != 0) begin exp_addr_q.push_back(p0a); exp_data_q.push_back(p0d); end
          last_winner = 0;
          p0v = 0;
        end else if (e1) begin
          if (p1a != 0) begin exp_addr_q.push_back(p1a); exp_data_q.push_back(p1d); end
          last_winner = 1;
          p1v = 0;
        end
      end
    end
  endtask

  task automatic req0(input logic [4:0] a, input logic [31:0] d);
    p0v = 1; p0a = a; p0d = d;
  endtask

  task automatic req1(input logic [4:0] a, input logic [31:0] d);
    p1v = 1; p1a = a; p1d = d;
  endtask

  // monitor: every write the DUT presents must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rf_wen) begin
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h expected no write at %0t", rf_waddr, rf_wdata, $time);
        end else begin
          chk("rf_waddr", rf_waddr, exp_addr_q.pop_front());
          chk("rf_wdata", rf_wdata, exp_data_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1; p0v = 0; p1v = 0; p0a = 0; p1a = 0; p0d = 0; p1d = 0;
    wb0_valid = 0; wb1_valid = 0; wb0_addr = 0; wb1_addr = 0; wb0_data = 0; wb1_data = 0;
    clear_left = 0; last_winner = 1; exp_cnt = 0;

    // reset and full clear pass with no requests
    step(1); step(1);
    mon_en = 1;
    for (int i = 0; i < NUM_REGS + 2; i++) step(0);
    chk("busy_after_clear", busy, 0);

    // four back-to-back conflicts with fresh payloads
    for (int i = 0; i < 4; i++) begin
      if (!p0v) req0(5'd3, 32'h1111_0000 + i);
      if (!p1v) req1(5'd4, 32'h2222_0000 + i);
      step(0);
    end
    p0v = 0; p1v = 0;
    step(0);
    chk("conflict_cnt_4", conflict_cnt, 16'd4);

    // same address conflict: wb0 first, wb1 data lands last
    req0(5'd7, 32'hA); req1(5'd7, 32'hB);
    step(0); step(0); step(0); step(0);

    // single write and r0 drop
    req0(5'd5, 32'hDEADBEEF);
    step(0); step(0); step(0);
    req1(5'd0, 32'h1234);
    step(0); step(0); step(0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (!p0v && ($urandom_range(0, 2) != 0)) req0(5'($urandom_range(0, 31)), $urandom);
      if (!p1v && ($urandom_range(0, 2) != 0)) req1(5'($urandom_range(0, 31)), $urandom);
      step(0);
    end
    p0v = 0; p1v = 0;
    step(0); step(0);

    // reset at the 10th clear write, wb0 waiting through the clear
    step(1); step(1);
    for (int i = 0; i < 9; i++) step(0);
    req0(5'd9, 32'hCAFE_F00D);
    step(1);
    for (int i = 0; i < NUM_REGS - 1; i++) step(0);
    chk("wb0_pending_through_clear", p0v, 1);
    step(0);
    chk("wb0_accepted_first_run", p0v, 0);
    step(0); step(0);

    // saturation of the conflict counter
    for (int i = 0; i < 65540; i++) begin
      if (!p0v) req0(5'($urandom_range(0, 31)), $urandom);
      if (!p1v) req1(5'($urandom_range(0, 31)), $urandom);
      step(0);
    end
    p0v = 0; p1v = 0;
    step(0);
    chk("conflict_cnt_sat", conflict_cnt, 16'hFFFF);
    step(0); step(0);
    chk("scoreboard_drained", exp_addr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
